zkn_crypto_pipe: RTL and testbench
==================================

Name: zkn_crypto_pipe

Overview:
- Parametrised, pipelined scalar-crypto functional unit for the CVA6 execute stage.
- Executes Zkne/Zknd AES32 byte-slice ops and Zknh SHA-256 sigma/sum ops on 32-bit operands.
- Sits behind the issue stage on the AES FU slot.
- Adds over the single-cycle unit: configurable latency, per-extension enables with illegal-op reporting, output back-pressure, flush, and in-flight tracking.

Parameters:
- LATENCY, 2, pipeline depth in cycles from accept to result (legal 1..4).
- TRANS_ID_BITS, 3, width of scoreboard transaction tag.
- ENABLE_AES, 1, 1 = AES32 ops legal.
- ENABLE_SHA, 1, 1 = SHA-256 ops legal.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- flush_i  in  1  kill all in-flight ops
- valid_i  in  1  op request
- ready_o  out  1  unit accepts op this cycle
- op_i  in  3  0 ESI, 1 ESMI, 2 DSI, 3 DSMI, 4 SIG0, 5 SIG1, 6 SUM0, 7 SUM1
- bs_i  in  2  AES byte select
- rs1_i  in  32  operand 1
- rs2_i  in  32  operand 2 (AES only)
- trans_id_i  in  TRANS_ID_BITS  tag
- result_valid_o  out  1  result available
- result_ready_i  in  1  writeback consumes result
- result_o  out  32  result
- trans_id_o  out  TRANS_ID_BITS  tag of result
- exception_o  out  1  op was illegal for this configuration
- inflight_o  out  3  number of valid pipeline stages (0..LATENCY)

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-high on rst_i.
- Reset values: all stage valid bits 0; result_valid_o=0; result_o=0; trans_id_o=0; exception_o=0; inflight_o=0. Reset mid-operation discards all in-flight ops.
- Pipeline structure: LATENCY register stages, each holding {valid, tag, exc, data}. Output ports are driven from the last stage.
- advance = !(last.valid && !result_ready_i) && !flush_i.
- ready_o = advance, so the pipe applies a global stall.
- Accept when valid_i && ready_o. Otherwise a bubble enters stage 1.
- Latency: an op accepted at edge N is at the output after edge N+LATENCY-1, i.e. result_valid_o rises LATENCY cycles after the valid_i cycle when there is no stall.
- Stall: while stalled, all stages hold and outputs stay stable.
- Output handshake: a result is consumed in a cycle with result_valid_o && result_ready_i.
- Flush:
  - At the next edge, all stage valid bits clear.
  - During the flush cycle, result_valid_o is forced to 0 and ready_o is 0.
  - A valid_i presented in the flush cycle is not accepted.
- Computation: done combinationally in stage 1; later stages only delay the value.
- AES common terms: x = rs2_i[8*bs+7 : 8*bs]; result = rs1_i XOR rol32(u, 8*bs).
  - ESI: u = {24'h0, sbox(x)}.
  - ESMI: s = sbox(x); u = {gm3(s), s, s, gm2(s)} (byte3..byte0).
  - DSI: u = {24'h0, invsbox(x)}.
  - DSMI: t = invsbox(x); u = {gmB(t), gmD(t), gm9(t), gmE(t)}.
  - GF(2^8) multiplies use polynomial 0x11B.
- SHA ops (operand rs1_i only):
  - SIG0 = ror7 ^ ror18 ^ srl3.
  - SIG1 = ror17 ^ ror19 ^ srl10.
  - SUM0 = ror2 ^ ror13 ^ ror22.
  - SUM1 = ror6 ^ ror11 ^ ror25.
- Illegal ops: an AES op with ENABLE_AES=0, or a SHA op with ENABLE_SHA=0, is still accepted. It flows through with exc=1 and data=0, and exception_o is asserted alongside result_valid_o.
- inflight_o = popcount of stage valid bits, registered consistently with the stages.
- Back-to-back: full throughput of one op per cycle while result_ready_i=1. Tags stay in order.

Test Plan:
- SIG0 with rs1=0x00000001, LATENCY=2 -> result_valid_o exactly 2 cycles later, result_o=0x02004000, exception_o=0.
- ESI rs1=0, rs2=0, bs=0 -> 0x00000063. ESI rs2=0x00005300, bs=1 -> 0x0000ED00.
- ESMI rs1=0, rs2=0, bs=0 -> 0xA56363C6.
- DSI rs1=0xDEADBEEF, rs2=0x63, bs=0 -> 0xDEADBEEF.
- DSMI rs1=0, rs2=0x7C, bs=0 -> 0x0B0D090E.
- Four back-to-back ops (tags 0..3) with result_ready_i low for 3 cycles mid-stream:
  - ready_o=0 while the output is held; no result lost or duplicated.
  - Tags return in order 0,1,2,3; inflight_o never exceeds LATENCY.
- flush_i with 2 ops in flight and valid_i=1 -> no result_valid_o afterwards, inflight_o=0, flushed-cycle op not accepted.
- rst_i asserted asynchronously mid-stream -> outputs 0 immediately.
- ENABLE_SHA=0, SUM1 op -> result_valid_o with exception_o=1, result_o=0.

Source files
------------

// File: rtl/zkn_crypto_pipe.sv
// Pipelined scalar-crypto unit: AES32 byte-slice ops and SHA-256 sigma/sum ops
// with configurable latency, global stall, flush and illegal-op reporting.
module zkn_crypto_pipe #(
    parameter int LATENCY       = 2,
    parameter int TRANS_ID_BITS = 3,
    parameter int ENABLE_AES    = 1,
    parameter int ENABLE_SHA    = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [2:0]               op_i,
    input  logic [1:0]               bs_i,
    input  logic [31:0]              rs1_i,
    input  logic [31:0]              rs2_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    output logic                     result_valid_o,
    input  logic                     result_ready_i,
    output logic [31:0]              result_o,
    output logic [TRANS_ID_BITS-1:0] trans_id_o,
    output logic                     exception_o,
    output logic [2:0]               inflight_o
);

    localparam int LAST = LATENCY - 1;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] p;
        r = '0;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ p;
            p = xtime(p);
        end
        return r;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires)
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] v, input int unsigned n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = ginv(x);
        return b ^ rol8(b, 1) ^ rol8(b, 2) ^ rol8(b, 3) ^ rol8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return ginv(rol8(s, 1) ^ rol8(s, 3) ^ rol8(s, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] ror32(input logic [31:0] v, input int unsigned n);
        return (v >> n) | (v << (32 - n));
    endfunction

    function automatic logic [31:0] rot_bytes(input logic [31:0] v, input logic [1:0] bs);
        case (bs)
            2'd0:    return v;
            2'd1:    return {v[23:0], v[31:24]};
            2'd2:    return {v[15:0], v[31:16]};
            default: return {v[7:0], v[31:8]};
        endcase
    endfunction

    logic [LATENCY-1:0]       vld_p;
    logic [LATENCY-1:0]       exc_p;
    logic [TRANS_ID_BITS-1:0] tag_p  [LATENCY];
    logic [31:0]              data_p [LATENCY];

    logic        advance;
    logic        accept;
    logic [7:0]  x;
    logic [7:0]  s;
    logic [7:0]  t;
    logic [31:0] u;
    logic [31:0] sha;
    logic [31:0] aes_res;
    logic [31:0] calc_data;
    logic        calc_exc;

    assign advance = !(vld_p[LAST] && !result_ready_i) && !flush_i;
    assign ready_o = advance;
    assign accept  = valid_i && advance;

    // Stage 1 input: all arithmetic happens here, later stages only delay it
    always_comb begin
        x   = rs2_i[{bs_i, 3'b000} +: 8];
        s   = sbox(x);
        t   = inv_sbox(x);
        u   = '0;
        sha = '0;
        case (op_i)
            3'd0: u = {24'h0, s};
            3'd1: u = {xtime(s) ^ s, s, s, xtime(s)};
            3'd2: u = {24'h0, t};
            3'd3: u = {gmul(t, 8'h0B), gmul(t, 8'h0D), gmul(t, 8'h09), gmul(t, 8'h0E)};
            3'd4: sha = ror32(rs1_i, 7) ^ ror32(rs1_i, 18) ^ (rs1_i >> 3);
            3'd5: sha = ror32(rs1_i, 17) ^ ror32(rs1_i, 19) ^ (rs1_i >> 10);
            3'd6: sha = ror32(rs1_i, 2) ^ ror32(rs1_i, 13) ^ ror32(rs1_i, 22);
            3'd7: sha = ror32(rs1_i, 6) ^ ror32(rs1_i, 11) ^ ror32(rs1_i, 25);
        endcase
        aes_res = rs1_i ^ rot_bytes(u, bs_i);
        if (!op_i[2]) begin
            calc_exc  = (ENABLE_AES == 0);
            calc_data = calc_exc ? 32'h0 : aes_res;
        end else begin
            calc_exc  = (ENABLE_SHA == 0);
            calc_data = calc_exc ? 32'h0 : sha;
        end
    end

    // Stage registers 1..LATENCY; a flush only drops the valid bits
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p <= '0;
            exc_p <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_p[i]  <= '0;
                data_p[i] <= '0;
            end
        end else if (flush_i) begin
            vld_p <= '0;
        end else if (advance) begin
            vld_p[0]  <= accept;
            exc_p[0]  <= calc_exc;
            tag_p[0]  <= trans_id_i;
            data_p[0] <= calc_data;
            for (int i = 1; i < LATENCY; i++) begin
                vld_p[i]  <= vld_p[i-1];
                exc_p[i]  <= exc_p[i-1];
                tag_p[i]  <= tag_p[i-1];
                data_p[i] <= data_p[i-1];
            end
        end
    end

    // Output stage
    assign result_valid_o = vld_p[LAST] && !flush_i;
    assign result_o       = data_p[LAST];
    assign trans_id_o     = tag_p[LAST];
    assign exception_o    = exc_p[LAST] && result_valid_o;

    always_comb begin
        inflight_o = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight_o = inflight_o + {2'b00, vld_p[i]};
        end
    end

endmodule

// File: tb/tb_zkn_crypto_pipe.sv
// Bench for zkn_crypto_pipe: vector table plus stall, flush, reset and
// illegal-op sequences, checked through an in-order scoreboard.
module tb_zkn_crypto_pipe;

    localparam int LAT = 2;
    localparam int TW  = 3;

    logic          clk = 1'b0;
    logic          rst, flush, valid, rr;
    logic [2:0]    op;
    logic [1:0]    bs;
    logic [31:0]   rs1, rs2;
    logic [TW-1:0] tid;

    logic          rdy, rv, exc;
    logic [31:0]   res;
    logic [TW-1:0] tido;
    logic [2:0]    infl;
    logic          rdy2, rv2, exc2;
    logic [31:0]   res2;
    logic [TW-1:0] tido2;
    logic [2:0]    infl2;

    always #5 clk = ~clk;

    zkn_crypto_pipe #(.LATENCY(LAT), .TRANS_ID_BITS(TW), .ENABLE_AES(1), .ENABLE_SHA(1)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid), .ready_o(rdy),
        .op_i(op), .bs_i(bs), .rs1_i(rs1), .rs2_i(rs2), .trans_id_i(tid),
        .result_valid_o(rv), .result_ready_i(rr), .result_o(res), .trans_id_o(tido),
        .exception_o(exc), .inflight_o(infl)
    );

    zkn_crypto_pipe #(.LATENCY(LAT), .TRANS_ID_BITS(TW), .ENABLE_AES(1), .ENABLE_SHA(0)) dut_nosha (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid), .ready_o(rdy2),
        .op_i(op), .bs_i(bs), .rs1_i(rs1), .rs2_i(rs2), .trans_id_i(tid),
        .result_valid_o(rv2), .result_ready_i(rr), .result_o(res2), .trans_id_o(tido2),
        .exception_o(exc2), .inflight_o(infl2)
    );

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  bs;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [TW-1:0] tag;
        logic [31:0]   res;
        logic [31:0]   res2;
        logic          exc2;
    } exp_t;

    vec_t        vt [16];
    exp_t        sb [$];
    exp_t        e;
    int          total = 0;
    int          bad = 0;
    bit          mon_on = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_res;
    logic [TW-1:0] prev_tid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] v, input int n);
        return (v >> n) | (v << (32 - n));
    endfunction

    function automatic logic [31:0] sha_ref(input logic [2:0] o, input logic [31:0] v);
        case (o)
            3'd4:    return rotr(v, 7) ^ rotr(v, 18) ^ (v >> 3);
            3'd5:    return rotr(v, 17) ^ rotr(v, 19) ^ (v >> 10);
            3'd6:    return rotr(v, 2) ^ rotr(v, 13) ^ rotr(v, 22);
            default: return rotr(v, 6) ^ rotr(v, 11) ^ rotr(v, 25);
        endcase
    endfunction

    // Drive one op and push its expectation in the cycle it is accepted
    task automatic issue(input logic [2:0] o, input logic [1:0] b, input logic [31:0] a1,
                         input logic [31:0] a2, input logic [TW-1:0] t, input logic [31:0] expv);
        bit accepted;
        accepted = 1'b0;
        op = o; bs = b; rs1 = a1; rs2 = a2; tid = t; valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (rdy) begin
                accepted = 1'b1;
                sb.push_back('{t, expv, o[2] ? 32'h0 : expv, o[2]});
            end
            @(posedge clk);
            #1;
            if (accepted) break;
        end
        valid = 1'b0;
        if (!accepted) check("issue_timeout", 32'(accepted), 32'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 100; n++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        #1;
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    // Output monitor: scoreboard pops, hold stability under stall, ready during stall
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else if (mon_on) begin
            if (prev_stall && !flush) begin
                check("hold_valid", 32'(rv), 32'd1);
                check("hold_data", res, prev_res);
                check("hold_tag", 32'(tido), 32'(prev_tid));
            end
            check("inflight_max", 32'(infl > 3'(LAT) || infl2 > 3'(LAT)), 32'd0);
            if (rv && !rr) begin
                check("ready_when_stalled", 32'(rdy), 32'd0);
                check("ready_when_stalled_nosha", 32'(rdy2), 32'd0);
            end
            if (rv && rr) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got tag %0d data %h required none", tido, res);
                end else begin
                    e = sb.pop_front();
                    check("result_tag", 32'(tido), 32'(e.tag));
                    check("result_data", res, e.res);
                    check("result_exc", 32'(exc), 32'd0);
                    check("nosha_valid", 32'(rv2), 32'd1);
                    check("nosha_tag", 32'(tido2), 32'(e.tag));
                    check("nosha_data", res2, e.res2);
                    check("nosha_exc", 32'(exc2), 32'(e.exc2));
                end
            end
            prev_stall = rv && !rr;
            prev_res   = res;
            prev_tid   = tido;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{3'd0, 2'd0, 32'h0,        32'h0,        32'h00000063};
        vt[1]  = '{3'd0, 2'd1, 32'h0,        32'h00005300, 32'h0000ED00};
        vt[2]  = '{3'd0, 2'd2, 32'h0,        32'h00010000, 32'h007C0000};
        vt[3]  = '{3'd0, 2'd3, 32'h12345678, 32'h0,        32'h71345678};
        vt[4]  = '{3'd1, 2'd0, 32'h0,        32'h0,        32'hA56363C6};
        vt[5]  = '{3'd1, 2'd0, 32'h0,        32'h00000001, 32'h847C7CF8};
        vt[6]  = '{3'd1, 2'd1, 32'h0,        32'h00005300, 32'hEDEDC12C};
        vt[7]  = '{3'd2, 2'd0, 32'hDEADBEEF, 32'h00000063, 32'hDEADBEEF};
        vt[8]  = '{3'd2, 2'd0, 32'h0,        32'h0,        32'h00000052};
        vt[9]  = '{3'd2, 2'd3, 32'h0,        32'h01000000, 32'h09000000};
        vt[10] = '{3'd3, 2'd0, 32'h0,        32'h0000007C, 32'h0B0D090E};
        vt[11] = '{3'd3, 2'd0, 32'h0,        32'h0,        32'h50A7F451};
        vt[12] = '{3'd4, 2'd0, 32'h00000001, 32'h0,        32'h02004000};
        vt[13] = '{3'd5, 2'd0, 32'h00000001, 32'h0,        32'h0000A000};
        vt[14] = '{3'd6, 2'd0, 32'h00000001, 32'h0,        32'h40080400};
        vt[15] = '{3'd7, 2'd0, 32'h00000001, 32'h0,        32'h04200080};

        rst = 1'b1; flush = 1'b0; valid = 1'b0; rr = 1'b1;
        op = '0; bs = '0; rs1 = '0; rs2 = '0; tid = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 32'(rv), 32'd0);
        check("reset_result", res, 32'd0);
        check("reset_tag", 32'(tido), 32'd0);
        check("reset_exc", 32'(exc), 32'd0);
        check("reset_inflight", 32'(infl), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        mon_on = 1'b1;

        // SIG0 latency: result visible exactly two cycles after the valid_i cycle
        op = 3'd4; bs = 2'd0; rs1 = 32'h1; rs2 = 32'h0; tid = 3'd5; valid = 1'b1;
        @(negedge clk);
        check("lat_accept", 32'(rdy), 32'd1);
        sb.push_back('{3'd5, 32'h02004000, 32'h0, 1'b1});
        @(posedge clk);
        #1;
        valid = 1'b0;
        @(negedge clk);
        check("lat_not_early", 32'(rv), 32'd0);
        @(negedge clk);
        check("lat_on_time", 32'(rv), 32'd1);
        @(posedge clk);
        #1;
        drain();

        for (int i = 0; i < 16; i++) begin
            issue(vt[i].op, vt[i].bs, vt[i].rs1, vt[i].rs2, TW'(i), vt[i].exp);
        end
        drain();

        // Four back-to-back ops with the writeback stalled for three cycles
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    issue(3'(4 + i), 2'd0, 32'hA5A5_0F0F + 32'(i), 32'h0, TW'(i),
                          sha_ref(3'(4 + i), 32'hA5A5_0F0F + 32'(i)));
                end
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                rr = 1'b0;
                @(negedge clk);
                check("stall_ready_low", 32'(rdy), 32'd0);
                check("stall_inflight", 32'(infl), 32'd2);
                repeat (3) @(posedge clk);
                #1;
                rr = 1'b1;
            end
        join
        drain();

        // Flush with two ops in flight and a new op offered in the flush cycle
        op = 3'd4; rs1 = 32'h1; tid = 3'd1; valid = 1'b1;
        @(posedge clk);
        #1;
        tid = 3'd2;
        @(posedge clk);
        #1;
        flush = 1'b1; tid = 3'd3;
        @(negedge clk);
        check("flush_inflight_before", 32'(infl), 32'd2);
        check("flush_valid_forced", 32'(rv), 32'd0);
        check("flush_ready_low", 32'(rdy), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0; valid = 1'b0;
        @(negedge clk);
        check("flush_inflight_after", 32'(infl), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("flush_no_result", 32'(rv), 32'd0);
        end
        @(posedge clk);
        #1;

        // Random SHA burst under random writeback back-pressure
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    logic [2:0]  o;
                    logic [31:0] a;
                    o = 3'(4 + $urandom_range(0, 3));
                    a = $urandom;
                    issue(o, 2'(i), a, 32'h0, TW'(i), sha_ref(o, a));
                end
            end
            begin
                repeat (40) begin
                    @(posedge clk);
                    #1;
                    rr = 1'($urandom_range(0, 1));
                end
                rr = 1'b1;
            end
        join
        rr = 1'b1;
        drain();

        // Asynchronous reset while results are in flight
        mon_on = 1'b0;
        op = 3'd6; rs1 = 32'h1; tid = 3'd4; valid = 1'b1;
        @(posedge clk);
        #1;
        tid = 3'd5;
        @(posedge clk);
        #1;
        valid = 1'b0;
        @(negedge clk);
        check("rst_pre_valid", 32'(rv), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_valid", 32'(rv), 32'd0);
        check("rst_async_result", res, 32'd0);
        check("rst_async_tag", 32'(tido), 32'd0);
        check("rst_async_inflight", 32'(infl), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_after_inflight", 32'(infl), 32'd0);
        sb.delete();
        mon_on = 1'b1;

        // SUM1 on the SHA-disabled instance flags an exception with zero data
        issue(3'd7, 2'd0, 32'h1, 32'h0, 3'd6, 32'h04200080);
        @(negedge clk);
        check("illegal_not_early", 32'(rv2), 32'd0);
        @(negedge clk);
        check("illegal_valid", 32'(rv2), 32'd1);
        check("illegal_exc", 32'(exc2), 32'd1);
        check("illegal_data", res2, 32'd0);
        @(posedge clk);
        #1;
        drain();

        mon_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
